vga_sprite: RTL and testbench

Single-sprite overlay stage placed directly downstream of the VGA timing/pattern generator, in the pixel clock domain. It consumes the generator's pixel coordinates, sync pulses and background colour, and overlays one 16x16 1-bpp sprite in a programmable colour at a programmable position. It re-emits sync and colour with a fixed two-cycle delay. Position, colour and enable are double-buffered and take effect only at the start of vertical blank, so there is no tearing.

---
 rtl/vga_pkg.sv | 24 ++
 rtl/vga_sprite_bitmap.sv | 31 +++
 rtl/vga_sprite.sv | 167 ++++++++++++++++
 tb/tb_vga_sprite.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA constants: 640x480 timing parameters and sprite register addresses.
package vga_pkg;

    localparam int unsigned VGA_X_PIXELS = 640;
    localparam int unsigned VGA_H_FRONT  = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BACK   = 48;
    localparam int unsigned VGA_H_TOTAL  = 800;

    localparam int unsigned VGA_Y_PIXELS = 480;
    localparam int unsigned VGA_V_FRONT  = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BACK   = 33;
    localparam int unsigned VGA_V_TOTAL  = 525;

    localparam int unsigned SPR_SIZE = 16;

    localparam logic [4:0] SPR_ADDR_POSX = 5'd16;
    localparam logic [4:0] SPR_ADDR_POSY = 5'd17;
    localparam logic [4:0] SPR_ADDR_COL  = 5'd18;
    localparam logic [4:0] SPR_ADDR_EN   = 5'd19;
    localparam logic [4:0] SPR_ADDR_CLR  = 5'd20;

endpackage

// File: rtl/vga_sprite_bitmap.sv
// 16x16-bit sprite bitmap: flop register file, one write port, one registered read port.
module vga_sprite_bitmap (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        we_i,
    input  logic [3:0]  waddr_i,
    input  logic [15:0] wdata_i,
    input  logic [3:0]  raddr_i,
    output logic [15:0] rdata_o
);

    logic [15:0] mem_q [16];
    logic [15:0] rdata_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            if (we_i) begin
                mem_q[waddr_i] <= wdata_i;
            end
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/vga_sprite.sv
// Single 16x16 1-bpp sprite overlay with a 2-cycle pipeline and vblank-latched registers.
// Optional sticky collision flag enabled by defining VGA_SPRITE_COLLISION_EN.
module vga_sprite
    import vga_pkg::*;
#(
    parameter int unsigned X_PIXELS = VGA_X_PIXELS,
    parameter int unsigned Y_PIXELS = VGA_Y_PIXELS
) (
    input  logic        vga_clk_i,
    input  logic        rst_i,
    input  logic [9:0]  pix_x_i,
    input  logic [9:0]  pix_y_i,
    input  logic        hs_i,
    input  logic        vs_i,
    input  logic [7:0]  col_i,
    input  logic        wr_en_i,
    input  logic [4:0]  wr_addr_i,
    input  logic [15:0] wr_data_i,
    output logic        hs_o,
    output logic        vs_o,
    output logic [7:0]  col_o,
    output logic        collision_o
);

    localparam logic [9:0] XMax    = 10'(X_PIXELS);
    localparam logic [9:0] YMax    = 10'(Y_PIXELS);
    localparam logic [9:0] SprSize = 10'(SPR_SIZE);

    // Shadow (CPU-visible) and active (display) copies of the sprite attributes
    logic [9:0] sh_pos_x_q, sh_pos_y_q, act_pos_x_q, act_pos_y_q;
    logic [7:0] sh_col_q, act_col_q;
    logic       sh_en_q, act_en_q;

    logic row_we, latch;

    always_comb begin
        row_we = wr_en_i && !wr_addr_i[4];
        latch  = (pix_x_i == 10'd0) && (pix_y_i == YMax);
    end

    always_ff @(posedge vga_clk_i or posedge rst_i) begin
        if (rst_i) begin
            sh_pos_x_q  <= '0;
            sh_pos_y_q  <= '0;
            sh_col_q    <= '0;
            sh_en_q     <= 1'b0;
            act_pos_x_q <= '0;
            act_pos_y_q <= '0;
            act_col_q   <= '0;
            act_en_q    <= 1'b0;
        end else begin
            if (wr_en_i) begin
                unique case (wr_addr_i)
                    SPR_ADDR_POSX: sh_pos_x_q <= wr_data_i[9:0];
                    SPR_ADDR_POSY: sh_pos_y_q <= wr_data_i[9:0];
                    SPR_ADDR_COL:  sh_col_q   <= wr_data_i[7:0];
                    SPR_ADDR_EN:   sh_en_q    <= wr_data_i[0];
                    default: ;
                endcase
            end
            // Non-blocking copy means a same-cycle write lands one frame later
            if (latch) begin
                act_pos_x_q <= sh_pos_x_q;
                act_pos_y_q <= sh_pos_y_q;
                act_col_q   <= sh_col_q;
                act_en_q    <= sh_en_q;
            end
        end
    end

    // Stage 1: hit test and bitmap row fetch
    logic [10:0] dx, dy;
    logic        inside_d, visible_d;
    logic [15:0] row_rd;

    always_comb begin
        dx        = {1'b0, pix_x_i} - {1'b0, act_pos_x_q};
        dy        = {1'b0, pix_y_i} - {1'b0, act_pos_y_q};
        inside_d  = !dx[10] && !dy[10] && (dx[9:0] < SprSize) && (dy[9:0] < SprSize);
        visible_d = (pix_x_i < XMax) && (pix_y_i < YMax);
    end

    vga_sprite_bitmap u_bitmap (
        .clk_i   (vga_clk_i),
        .rst_i   (rst_i),
        .we_i    (row_we),
        .waddr_i (wr_addr_i[3:0]),
        .wdata_i (wr_data_i),
        .raddr_i (dy[3:0]),
        .rdata_o (row_rd)
    );

    logic [3:0] dx_q;
    logic       inside_q, visible_q, hs_d1_q, vs_d1_q;
    logic [7:0] col_d1_q;

    always_ff @(posedge vga_clk_i or posedge rst_i) begin
        if (rst_i) begin
            dx_q      <= '0;
            inside_q  <= 1'b0;
            visible_q <= 1'b0;
            hs_d1_q   <= 1'b0;
            vs_d1_q   <= 1'b0;
            col_d1_q  <= '0;
        end else begin
            dx_q      <= dx[3:0];
            inside_q  <= inside_d;
            visible_q <= visible_d;
            hs_d1_q   <= hs_i;
            vs_d1_q   <= vs_i;
            col_d1_q  <= col_i;
        end
    end

    // Stage 2: composite
    logic       draw;
    logic [7:0] col_d;

    always_comb begin
        draw  = act_en_q && inside_q && visible_q && row_rd[4'd15 - dx_q];
        col_d = draw ? act_col_q : col_d1_q;
    end

    logic       hs_q, vs_q;
    logic [7:0] col_q;

    always_ff @(posedge vga_clk_i or posedge rst_i) begin
        if (rst_i) begin
            hs_q  <= 1'b0;
            vs_q  <= 1'b0;
            col_q <= '0;
        end else begin
            hs_q  <= hs_d1_q;
            vs_q  <= vs_d1_q;
            col_q <= col_d;
        end
    end

    assign hs_o  = hs_q;
    assign vs_o  = vs_q;
    assign col_o = col_q;

`ifdef VGA_SPRITE_COLLISION_EN
    logic coll_q, coll_d, coll_set, coll_clr;

    always_comb begin
        coll_set = draw && (col_d1_q != 8'h00);
        coll_clr = wr_en_i && (wr_addr_i == SPR_ADDR_CLR);
        coll_d   = coll_q;
        if (coll_clr) coll_d = 1'b0;
        if (coll_set) coll_d = 1'b1;
    end

    always_ff @(posedge vga_clk_i or posedge rst_i) begin
        if (rst_i) begin
            coll_q <= 1'b0;
        end else begin
            coll_q <= coll_d;
        end
    end

    assign collision_o = coll_q;
`else
    assign collision_o = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sprite.sv
// Directed self-checking bench for vga_sprite: latency, overlay, latching, clipping, collision.
module tb_vga_sprite;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  px, py;
    logic        hs, vs;
    logic [7:0]  col;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic        hs_o, vs_o, collision_o;
    logic [7:0]  col_o;

    int checks   = 0;
    int failures = 0;

    vga_sprite dut (
        .vga_clk_i   (clk),
        .rst_i       (rst),
        .pix_x_i     (px),
        .pix_y_i     (py),
        .hs_i        (hs),
        .vs_i        (vs),
        .col_i       (col),
        .wr_en_i     (wr_en),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data),
        .hs_o        (hs_o),
        .vs_o        (vs_o),
        .col_o       (col_o),
        .collision_o (collision_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [9:0] x, input logic [9:0] y, input logic [7:0] c);
        px  = x;
        py  = y;
        col = c;
    endtask

    task automatic wr(input logic [4:0] a, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic latch_ev();
        drive(10'd0, 10'd480, 8'h5A);
        tick();
        drive(10'd700, 10'd700, 8'h5A);
    endtask

    task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic [7:0] c,
                       input logic [7:0] exp, input string tag);
        drive(x, y, c);
        tick();
        tick();
        check(tag, 32'(col_o), 32'(exp));
    endtask

    logic [9:0] hist [10];

    initial begin
        rst = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        hs = 1'b1; vs = 1'b1;
        drive(10'd700, 10'd700, 8'h5A);
        tick();
        tick();
        check("rst_col", 32'(col_o), 32'h0);
        check("rst_hsvs", 32'({hs_o, vs_o}), 32'h0);
        check("rst_coll", 32'(collision_o), 32'h0);
        rst = 1'b0;

        // Pass-through latency
        for (int i = 0; i < 10; i++) begin
            hs  = i[0];
            vs  = i[1];
            col = (i < 5) ? 8'h5A : (8'h5A ^ 8'(i));
            hist[i] = {hs, vs, col};
            tick();
            check("delay2", 32'({hs_o, vs_o, col_o}), (i == 0) ? 32'h0 : 32'(hist[i-1]));
        end
        hs = 1'b0; vs = 1'b0;

        // Basic overlay, rows 8001 at (100,50)
        for (int r = 0; r < 16; r++) wr(5'(r), 16'h8001);
        wr(5'd16, 16'd100);
        wr(5'd17, 16'd50);
        wr(5'd18, 16'h00E0);
        wr(5'd19, 16'h0001);
        pix(10'd100, 10'd50, 8'h5A, 8'h5A, "before_latch");
        latch_ev();
        pix(10'd100, 10'd50, 8'h5A, 8'hE0, "x100_y50");
        pix(10'd115, 10'd50, 8'h5A, 8'hE0, "x115_y50");
        pix(10'd99,  10'd50, 8'h5A, 8'h5A, "x99");
        pix(10'd101, 10'd50, 8'h5A, 8'h5A, "x101");
        pix(10'd116, 10'd50, 8'h5A, 8'h5A, "x116");
        pix(10'd100, 10'd65, 8'h5A, 8'hE0, "y65");
        pix(10'd115, 10'd65, 8'h5A, 8'hE0, "x115_y65");
        pix(10'd100, 10'd66, 8'h5A, 8'h5A, "y66");
        pix(10'd100, 10'd49, 8'h5A, 8'h5A, "y49");

        // Mid-frame position write is deferred to the latch
        drive(10'd300, 10'd100, 8'h5A);
        wr(5'd16, 16'd200);
        pix(10'd100, 10'd60, 8'h5A, 8'hE0, "old_pos_held");
        pix(10'd200, 10'd60, 8'h5A, 8'h5A, "new_pos_early");
        latch_ev();
        pix(10'd200, 10'd60, 8'h5A, 8'hE0, "new_pos");
        pix(10'd100, 10'd60, 8'h5A, 8'h5A, "old_pos_gone");

        // Edge clipping
        for (int r = 0; r < 16; r++) wr(5'(r), 16'hFFFF);
        wr(5'd16, 16'd632);
        wr(5'd17, 16'd472);
        latch_ev();
        pix(10'd632, 10'd472, 8'h5A, 8'hE0, "clip_tl");
        pix(10'd639, 10'd479, 8'h5A, 8'hE0, "clip_br");
        pix(10'd640, 10'd479, 8'h5A, 8'h5A, "clip_x640");
        pix(10'd635, 10'd480, 8'h5A, 8'h5A, "clip_y480");
        pix(10'd631, 10'd472, 8'h5A, 8'h5A, "clip_x631");
        pix(10'd632, 10'd471, 8'h5A, 8'h5A, "clip_y471");
        wr(5'd16, 16'd1020);
        wr(5'd17, 16'd0);
        latch_ev();
        pix(10'd0,  10'd0, 8'h5A, 8'h5A, "nowrap_x0");
        pix(10'd3,  10'd0, 8'h5A, 8'h5A, "nowrap_x3");
        pix(10'd11, 10'd5, 8'h5A, 8'h5A, "nowrap_x11");

        // Ignored address and write on the latch cycle
        wr(5'd16, 16'd300);
        wr(5'd17, 16'd300);
        latch_ev();
        pix(10'd300, 10'd300, 8'h5A, 8'hE0, "pos300");
        drive(10'd700, 10'd700, 8'h5A);
        wr(5'd25, 16'h0000);
        pix(10'd300, 10'd309, 8'h5A, 8'hE0, "addr25_row");
        latch_ev();
        pix(10'd300, 10'd300, 8'h5A, 8'hE0, "addr25_pos");
        pix(10'd300, 10'd309, 8'h5A, 8'hE0, "addr25_row2");
        wr(5'd16, 16'd400);
        drive(10'd0, 10'd480, 8'h5A);
        wr(5'd16, 16'd500);
        drive(10'd700, 10'd700, 8'h5A);
        pix(10'd400, 10'd300, 8'h5A, 8'hE0, "latchwr_old");
        pix(10'd500, 10'd300, 8'h5A, 8'h5A, "latchwr_new_early");
        latch_ev();
        pix(10'd500, 10'd300, 8'h5A, 8'hE0, "latchwr_new");
        pix(10'd400, 10'd300, 8'h5A, 8'h5A, "latchwr_old_gone");

        // Collision flag
        wr(5'd16, 16'd10);
        wr(5'd17, 16'd10);
        latch_ev();
        drive(10'd700, 10'd700, 8'h5A);
        tick();
        tick();
`ifdef VGA_SPRITE_COLLISION_EN
        wr(5'd20, 16'h0000);
        check("coll_clr0", 32'(collision_o), 32'h0);
        pix(10'd10, 10'd10, 8'h00, 8'hE0, "coll_bg00_col");
        check("coll_bg00", 32'(collision_o), 32'h0);
        pix(10'd10, 10'd10, 8'h01, 8'hE0, "coll_bg01_col");
        check("coll_set", 32'(collision_o), 32'h1);
        pix(10'd700, 10'd700, 8'h01, 8'h01, "coll_idle_col");
        check("coll_sticky", 32'(collision_o), 32'h1);
        wr(5'd20, 16'h0000);
        check("coll_clr1", 32'(collision_o), 32'h0);
        drive(10'd10, 10'd10, 8'h01);
        tick();
        drive(10'd700, 10'd700, 8'h01);
        wr(5'd20, 16'h0000);
        tick();
        tick();
        check("coll_set_wins", 32'(collision_o), 32'h1);
        wr(5'd20, 16'h0000);
        check("coll_clr2", 32'(collision_o), 32'h0);
`else
        pix(10'd10, 10'd10, 8'h01, 8'hE0, "nocoll_col");
        check("nocoll_hit", 32'(collision_o), 32'h0);
        wr(5'd20, 16'h0000);
        check("nocoll_clr", 32'(collision_o), 32'h0);
`endif

        // Reset mid-frame
        hs = 1'b1; vs = 1'b1;
        pix(10'd10, 10'd10, 8'h01, 8'hE0, "pre_reset");
        check("pre_reset_hsvs", 32'({hs_o, vs_o}), 32'h3);
        rst = 1'b1;
        #1;
        check("midrst_col", 32'(col_o), 32'h0);
        check("midrst_hsvs", 32'({hs_o, vs_o}), 32'h0);
        tick();
        rst = 1'b0;
        hs = 1'b0; vs = 1'b0;
        pix(10'd10, 10'd10, 8'h01, 8'h01, "post_reset_disabled");
        wr(5'd19, 16'h0001);
        latch_ev();
        pix(10'd10, 10'd10, 8'h01, 8'h01, "post_reset_bitmap0");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
